lock_code_tx: RTL and testbench

LOCK_CODE_TX -- requirements
Module: lock_code_tx

---
 rtl/lock_code_tx.sv | 161 ++++++++++++++++
 tb/tb_lock_code_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lock_code_tx.sv
// Serial unlock-code transmitter: sends a latched 2-bit symbol sequence,
// waits for the lock to answer, and resends a bounded number of times.
module lock_code_tx #(
    parameter int MAX_LEN = 8,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 4,
    parameter int RETRIES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*MAX_LEN-1:0]   code,
    input  logic [3:0]             len,
    input  logic                   unlock_in,
    output logic [1:0]             sym_out,
    output logic                   sym_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   fail
);
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W  = (GAP > 1)     ? $clog2(GAP)     : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RTRY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2*MAX_LEN-1:0] code_q, code_d;
    logic [3:0]           len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [RTRY_W-1:0]    rtry_q, rtry_d;
    logic [1:0]           sym_q, sym_d;
    logic                 vld_q, vld_d;
    logic                 fail_q, fail_d;

    logic                 len_ok, last;
    logic [IDX_W-1:0]     idx_inc;

    // The unused symbol code 11 goes out as 00 but still counts as a symbol.
    function automatic logic [1:0] enc(input logic [1:0] s);
        return (s == 2'b11) ? 2'b00 : s;
    endfunction

    assign len_ok  = (len != 4'd0) && (32'(len) <= 32'(MAX_LEN));
    assign last    = (idx_q == IDX_W'(len_q - 4'd1));
    assign idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        wait_d  = wait_q;
        rtry_d  = rtry_q;
        sym_d   = 2'b00;
        vld_d   = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A start coinciding with a fail pulse is dropped.
                if (start && !fail_q) begin
                    if (len_ok) begin
                        state_d = S_SEND;
                        code_d  = code;
                        len_d   = len;
                        idx_d   = '0;
                        rtry_d  = '0;
                        sym_d   = enc(code[1:0]);
                        vld_d   = 1'b1;
                    end else begin
                        fail_d  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else if (last) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end else begin
                    idx_d   = idx_inc;
                    sym_d   = enc(code_q[2*idx_inc +: 2]);
                    vld_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    if (last) begin
                        state_d = S_WAIT;
                        wait_d  = '0;
                    end else begin
                        state_d = S_SEND;
                        idx_d   = idx_inc;
                        sym_d   = enc(code_q[2*idx_inc +: 2]);
                        vld_d   = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_WAIT: begin
                if (unlock_in) begin
                    state_d = S_DONE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    if (rtry_q < RTRY_W'(RETRIES)) begin
                        state_d = S_SEND;
                        rtry_d  = rtry_q + RTRY_W'(1);
                        idx_d   = '0;
                        sym_d   = enc(code_q[1:0]);
                        vld_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        fail_d  = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            wait_q  <= '0;
            rtry_q  <= '0;
            sym_q   <= 2'b00;
            vld_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            wait_q  <= wait_d;
            rtry_q  <= rtry_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
            fail_q  <= fail_d;
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = vld_q;
    assign fail      = fail_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_lock_code_tx.sv
// Cycle scoreboard for lock_code_tx: a default instance (A) and a GAP=2 instance (B).
module tb_lock_code_tx;
  logic        clk, rst, st_a, st_b, unl;
  logic [15:0] code;
  logic [3:0]  len;
  logic [1:0]  a_sym, b_sym;
  logic        a_vld, a_busy, a_done, a_fail;
  logic        b_vld, b_busy, b_done, b_fail;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [5:0] qa[$];
  logic [5:0] qb[$];

  // expected vector = {sym_out, sym_valid, busy, done, fail}
  localparam logic [5:0] W_IDLE = 6'b000000;
  localparam logic [5:0] W_BUSY = 6'b000100;
  localparam logic [5:0] W_DONE = 6'b000110;
  localparam logic [5:0] W_FAIL = 6'b000001;

  lock_code_tx u_a (
    .clk(clk), .rst(rst), .start(st_a), .code(code), .len(len), .unlock_in(unl),
    .sym_out(a_sym), .sym_valid(a_vld), .busy(a_busy), .done(a_done), .fail(a_fail)
  );

  lock_code_tx #(.GAP(2)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .code(code), .len(len), .unlock_in(unl),
    .sym_out(b_sym), .sym_valid(b_vld), .busy(b_busy), .done(b_done), .fail(b_fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk("A", {a_sym, a_vld, a_busy, a_done, a_fail}, e);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk("B", {b_sym, b_vld, b_busy, b_done, b_fail}, e);
    end
  end

  function automatic logic [5:0] symw(input logic [15:0] c, input int i);
    logic [1:0] s;
    s = c[2*i +: 2];
    if (s == 2'b11) s = 2'b00;
    return {s, 4'b1100};
  endfunction

  // Declare expected outputs for the current cycle, then advance one cycle.
  task automatic tick(input logic [5:0] ea, input logic [5:0] eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk); #1;
    cyc++;
    st_a = 1'b0; st_b = 1'b0; unl = 1'b0;
  endtask

  task automatic tk(input bit onb, input logic [5:0] e);
    if (onb) tick(W_IDLE, e);
    else     tick(e, W_IDLE);
  endtask

  task automatic send_body(input logic [15:0] c, input int n, input int gap,
                           input bit onb, input bit poke);
    for (int i = 0; i < n; i++) begin
      if (poke && i == 1) begin
        if (onb) st_b = 1'b1; else st_a = 1'b1;
        unl = 1'b1;
      end
      tk(onb, symw(c, i));
      for (int g = 0; g < gap; g++) tk(onb, W_BUSY);
    end
  endtask

  task automatic wait_cycles(input bit onb, input int n);
    for (int w = 0; w < n; w++) tk(onb, W_BUSY);
  endtask

  initial begin
    rst = 1'b1; st_a = 1'b0; st_b = 1'b0; unl = 1'b0;
    code = 16'h0019; len = 4'd3;
    @(posedge clk); #1;

    // reset state, and reset wins over start
    st_a = 1'b1; st_b = 1'b1;
    tick(W_IDLE, W_IDLE);
    rst = 1'b0;
    tick(W_IDLE, W_IDLE);
    tick(W_IDLE, W_IDLE);

    // basic send 01,10,01 with unlock in first WAIT cycle; start during done ignored
    st_a = 1'b1;
    tk(0, W_IDLE);
    send_body(16'h0019, 3, 0, 0, 0);
    unl = 1'b1;
    tk(0, W_BUSY);
    st_a = 1'b1;
    tk(0, W_DONE);
    tk(0, W_IDLE);
    tk(0, W_IDLE);

    // GAP=2 instance; inputs change after latching
    st_b = 1'b1;
    tk(1, W_IDLE);
    code = 16'hFFFF; len = 4'd0;
    send_body(16'h0019, 3, 2, 1, 0);
    unl = 1'b1;
    tk(1, W_BUSY);
    tk(1, W_DONE);
    tk(1, W_IDLE);

    // no unlock: two full sends, 4 WAIT cycles each, then fail; includes an 11 symbol
    // and a start/unlock poke mid-send; start during the fail pulse ignored
    code = 16'h0027; len = 4'd4;
    st_a = 1'b1;
    tk(0, W_IDLE);
    code = 16'h0000; len = 4'd1;
    send_body(16'h0027, 4, 0, 0, 1);
    wait_cycles(0, 4);
    send_body(16'h0027, 4, 0, 0, 0);
    wait_cycles(0, 4);
    code = 16'h0019; len = 4'd3;
    st_a = 1'b1;
    tk(0, W_FAIL);
    tk(0, W_IDLE);
    tk(0, W_IDLE);

    // illegal lengths
    len = 4'd0; st_a = 1'b1;
    tk(0, W_IDLE);
    tk(0, W_FAIL);
    tk(0, W_IDLE);
    len = 4'd9; st_a = 1'b1;
    tk(0, W_IDLE);
    tk(0, W_FAIL);
    tk(0, W_IDLE);

    // reset during symbol 1, then a clean restart
    code = 16'h0019; len = 4'd3; st_a = 1'b1;
    tk(0, W_IDLE);
    tk(0, symw(16'h0019, 0));
    rst = 1'b1;
    tk(0, symw(16'h0019, 1));
    rst = 1'b0;
    tk(0, W_IDLE);
    tk(0, W_IDLE);
    st_a = 1'b1;
    tk(0, W_IDLE);
    send_body(16'h0019, 3, 0, 0, 0);
    unl = 1'b1;
    tk(0, W_BUSY);
    tk(0, W_DONE);
    tk(0, W_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
